// File: rtl/stack_engine_if.sv
// Request handshake and stack-memory bus shared between the stack engine and its environment.
// The engine uses the slave view; the requester/memory side uses the master view.
interface stack_engine_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [1:0]  req_dst;
   logic [15:0] push_data;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic        mem_wait;
   logic [7:0]  mem_rdata;

   modport slave (
      input  req_valid, req_op, req_dst, push_data, mem_wait, mem_rdata,
      output req_ready, mem_addr, mem_wdata, mem_we, mem_re
   );

   modport master (
      output req_valid, req_op, req_dst, push_data, mem_wait, mem_rdata,
      input  req_ready, mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface

// File: rtl/stack_engine.sv
// 6502-style stack sequencer: runs push/pull bus cycles on the stack page and writes
// the new stack pointer and any pulled value back to the register file, one load per cycle.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a request; reserved ops raise err next cycle
// PUSH      | write one byte at {page,sp_lo}, then sp_lo--
// PULL_ADDR | read request at {page,sp_lo+1}, then sp_lo++
// PULL_DATA | capture read byte (first -> low, second -> high)
// WB_SP     | load_sp with {sp_hi,sp_lo}; pushes finish here
// WB_DST    | load the pulled value into the selected register
module stack_engine #(
   parameter logic [7:0] STACK_PAGE = 8'h01
) (
   input  logic          clk,
   input  logic          reset,
   stack_engine_if.slave bus,
   input  logic [15:0]   sp,
   output logic [15:0]   data_out,
   output logic          load_sp,
   output logic          load_accumulator,
   output logic          load_p,
   output logic          load_x,
   output logic          load_y,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [2:0] {
      IDLE, PUSH, PULL_ADDR, PULL_DATA, WB_SP, WB_DST
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  op_q;      // bit 0: two-byte op, bit 1: pull
   logic [1:0]  dst_q;
   logic [15:0] push_q;
   logic [7:0]  sp_hi, sp_lo;
   logic [7:0]  lo_q, hi_q;
   logic [1:0]  cnt;
   logic        err_q;
   logic        accept, reserved;
   logic [7:0]  sp_lo_inc;

   assign sp_lo_inc = sp_lo + 8'd1;
   assign err       = err_q;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and Moore output decode
   always_comb begin
      state_nxt        = state;
      accept           = 1'b0;
      reserved         = 1'b0;
      bus.req_ready    = 1'b0;
      bus.mem_addr     = '0;
      bus.mem_wdata    = '0;
      bus.mem_we       = 1'b0;
      bus.mem_re       = 1'b0;
      data_out         = '0;
      load_sp          = 1'b0;
      load_accumulator = 1'b0;
      load_p           = 1'b0;
      load_x           = 1'b0;
      load_y           = 1'b0;
      busy             = 1'b0;
      done             = 1'b0;
      case (state)
         IDLE: begin
            // ready stays low while reset is held so every output reads 0 during reset
            bus.req_ready = reset;
            if (bus.req_valid) begin
               if (bus.req_op[2]) begin
                  reserved = 1'b1;
               end else begin
                  accept    = 1'b1;
                  state_nxt = bus.req_op[1] ? PULL_ADDR : PUSH;
               end
            end
         end
         PUSH: begin
            busy          = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = {STACK_PAGE, sp_lo};
            bus.mem_wdata = (op_q[0] && cnt == 2'd2) ? push_q[15:8] : push_q[7:0];
            if (!bus.mem_wait && cnt == 2'd1) state_nxt = WB_SP;
         end
         PULL_ADDR: begin
            busy         = 1'b1;
            bus.mem_re   = 1'b1;
            bus.mem_addr = {STACK_PAGE, sp_lo_inc};
            if (!bus.mem_wait) state_nxt = PULL_DATA;
         end
         PULL_DATA: begin
            busy      = 1'b1;
            state_nxt = (cnt == 2'd1) ? WB_SP : PULL_ADDR;
         end
         WB_SP: begin
            busy     = 1'b1;
            data_out = {sp_hi, sp_lo};
            load_sp  = 1'b1;
            if (op_q[1]) begin
               state_nxt = WB_DST;
            end else begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         WB_DST: begin
            busy     = 1'b1;
            done     = 1'b1;
            data_out = op_q[0] ? {hi_q, lo_q} : {8'h00, lo_q};
            case (dst_q)
               2'd0:    load_accumulator = 1'b1;
               2'd1:    load_p           = 1'b1;
               2'd2:    load_x           = 1'b1;
               default: load_y           = 1'b1;
            endcase
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, stack-pointer arithmetic, pulled-byte capture and err pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q   <= '0;
         dst_q  <= '0;
         push_q <= '0;
         sp_hi  <= '0;
         sp_lo  <= '0;
         lo_q   <= '0;
         hi_q   <= '0;
         cnt    <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= reserved;
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q   <= bus.req_op[1:0];
                  dst_q  <= bus.req_dst;
                  push_q <= bus.push_data;
                  sp_hi  <= sp[15:8];
                  sp_lo  <= sp[7:0];
                  cnt    <= bus.req_op[0] ? 2'd2 : 2'd1;
               end
            end
            PUSH: begin
               if (!bus.mem_wait) begin
                  sp_lo <= sp_lo - 8'd1;
                  cnt   <= cnt - 2'd1;
               end
            end
            PULL_ADDR: begin
               if (!bus.mem_wait) sp_lo <= sp_lo_inc;
            end
            PULL_DATA: begin
               if (op_q[0] && cnt == 2'd1) hi_q <= bus.mem_rdata;
               else                        lo_q <= bus.mem_rdata;
               cnt <= cnt - 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: per-cycle expected output vectors are generated from the
// operation rules (bytes pushed/pulled, stalls, writeback order) and compared at negedge.
module tb_stack_engine;
   localparam logic [7:0] PAGE = 8'h01;

   typedef struct packed {
      logic        ready;
      logic        busy;
      logic        we;
      logic        re;
      logic        done;
      logic        err;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [15:0] dout;
      logic [4:0]  ld;      // {sp, accumulator, p, x, y}
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] sp_in;
   logic [15:0] data_out;
   logic        load_sp, load_accumulator, load_p, load_x, load_y;
   logic        busy, done, err;

   stack_engine_if bus();

   stack_engine #(.STACK_PAGE(PAGE)) dut (
      .clk              (clk),
      .reset            (reset),
      .bus              (bus),
      .sp               (sp_in),
      .data_out         (data_out),
      .load_sp          (load_sp),
      .load_accumulator (load_accumulator),
      .load_p           (load_p),
      .load_x           (load_x),
      .load_y           (load_y),
      .busy             (busy),
      .done             (done),
      .err              (err)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   vec_t        exp_q[$];
   vec_t        e;
   logic [7:0]  mem[256];
   logic [7:0]  ref_mem[256];
   bit          rd_valid;
   logic [7:0]  rd_addr;
   bit          err_flag = 0;
   int          abort_at = -1;
   int          op_cyc = 0;
   bit          aborted = 0;
   logic [15:0] m_sp_wb, m_dst;
   int          m_lat;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, want);
      end
   endtask

   // compare DUT outputs against the expected vector for this cycle
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("req_ready", 16'(bus.req_ready), 16'(e.ready));
         chk("busy",      16'(busy),          16'(e.busy));
         chk("mem_we",    16'(bus.mem_we),    16'(e.we));
         chk("mem_re",    16'(bus.mem_re),    16'(e.re));
         chk("done",      16'(done),          16'(e.done));
         chk("err",       16'(err),           16'(e.err));
         chk("mem_addr",  bus.mem_addr,       e.addr);
         chk("mem_wdata", 16'(bus.mem_wdata), 16'(e.wdata));
         chk("data_out",  data_out,           e.dout);
         chk("loads", 16'({load_sp, load_accumulator, load_p, load_x, load_y}), 16'(e.ld));
      end
   end

   function automatic vec_t idle_vec();
      vec_t v;
      v = '0;
      v.ready = 1'b1;
      return v;
   endfunction

   // memory responder sampled mid-cycle, read data presented the cycle after an accepted read
   task automatic step();
      @(negedge clk);
      if (bus.mem_we && !bus.mem_wait && bus.mem_addr[15:8] == PAGE)
         mem[bus.mem_addr[7:0]] = bus.mem_wdata;
      rd_valid = bus.mem_re && !bus.mem_wait;
      rd_addr  = bus.mem_addr[7:0];
      @(posedge clk);
      #1;
      bus.mem_rdata = rd_valid ? mem[rd_addr] : 8'($urandom);
   endtask

   task automatic cycle(input vec_t v, input bit w, input bit raise_err);
      vec_t vv;
      bit   re_next;
      if (aborted) return;
      vv = v;
      re_next = raise_err;
      if (abort_at >= 0 && op_cyc == abort_at) begin
         reset    = 1'b0;
         aborted  = 1;
         vv       = '0;
         err_flag = 0;
         re_next  = 0;
      end else begin
         vv.err = err_flag;
      end
      bus.mem_wait = w;
      exp_q.push_back(vv);
      err_flag = re_next;
      op_cyc++;
      step();
   endtask

   task automatic junk();
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_op    = 3'($urandom);
      bus.req_dst   = 2'($urandom);
      bus.push_data = 16'($urandom);
      sp_in         = 16'($urandom);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         bus.req_valid = 1'b0;
         cycle(idle_vec(), 1'($urandom_range(0, 1)), 0);
      end
   endtask

   task automatic reserved_req(input int op);
      bus.req_valid = 1'b1;
      bus.req_op    = 3'(op);
      cycle(idle_vec(), 1'b0, 1);
      bus.req_valid = 1'b0;
   endtask

   function automatic int rand_wait();
      return ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 3));
   endfunction

   task automatic run_op(input int op, input int dst, input logic [15:0] pd,
                         input logic [15:0] spv, input int w0, input int w1);
      vec_t        v;
      int          n, wi, lat;
      logic [7:0]  s, b;
      logic [15:0] val;
      n = (op == 1 || op == 3) ? 2 : 1;
      s = spv[7:0];
      bus.req_valid = 1'b1;
      bus.req_op    = 3'(op);
      bus.req_dst   = 2'(dst);
      bus.push_data = pd;
      sp_in         = spv;
      cycle(idle_vec(), 1'b0, 0);
      op_cyc = 0;
      lat = 0;
      val = '0;
      for (int i = 0; i < n; i++) begin
         wi = (i == 0) ? w0 : w1;
         if (op < 2) begin
            b = (n == 2 && i == 0) ? pd[15:8] : pd[7:0];
            for (int w = 0; w <= wi; w++) begin
               v = '0; v.busy = 1'b1; v.we = 1'b1; v.addr = {PAGE, s}; v.wdata = b;
               junk();
               cycle(v, w < wi, 0);
               lat++;
            end
            ref_mem[s] = b;
            s = s - 8'd1;
         end else begin
            s = s + 8'd1;
            for (int w = 0; w <= wi; w++) begin
               v = '0; v.busy = 1'b1; v.re = 1'b1; v.addr = {PAGE, s};
               junk();
               cycle(v, w < wi, 0);
               lat++;
            end
            v = '0; v.busy = 1'b1;
            junk();
            cycle(v, 1'($urandom_range(0, 1)), 0);
            lat++;
            val = val | (16'(ref_mem[s]) << (8 * i));
         end
      end
      v = '0; v.busy = 1'b1; v.ld = 5'b10000; v.dout = {spv[15:8], s}; v.done = (op < 2);
      m_sp_wb = v.dout;
      junk();
      cycle(v, 1'($urandom_range(0, 1)), 0);
      lat++;
      if (op >= 2) begin
         v = '0; v.busy = 1'b1; v.done = 1'b1; v.dout = val;
         v.ld = 5'(5'b01000 >> dst);
         m_dst = val;
         junk();
         cycle(v, 1'($urandom_range(0, 1)), 0);
         lat++;
      end
      m_lat = lat;
      bus.req_valid = 1'b0;
   endtask

   int r_op;

   initial begin
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = '0;
      bus.req_dst   = '0;
      bus.push_data = '0;
      bus.mem_wait  = 1'b0;
      bus.mem_rdata = '0;
      sp_in         = '0;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      @(posedge clk);
      #1;
      cycle('0, 1'b0, 0);
      cycle('0, 1'b0, 0);
      reset = 1'b1;
      idle(2);

      // single-byte push
      run_op(0, 0, 16'h0042, 16'h00FD, 0, 0);
      chk("push1_sp", m_sp_wb, 16'h00FC);
      chk("push1_lat", 16'(m_lat), 16'd2);
      chk("push1_mem", 16'(mem[8'hFD]), 16'h0042);

      // two-byte push, back to back
      run_op(1, 0, 16'h1234, 16'h00FF, 0, 0);
      chk("push2_sp", m_sp_wb, 16'h00FD);
      chk("push2_lat", 16'(m_lat), 16'd3);
      chk("push2_hi", 16'(mem[8'hFF]), 16'h0012);
      chk("push2_lo", 16'(mem[8'hFE]), 16'h0034);
      idle(1);

      // two-byte pull into x
      mem[8'hFE] = 8'h34; ref_mem[8'hFE] = 8'h34;
      mem[8'hFF] = 8'h12; ref_mem[8'hFF] = 8'h12;
      run_op(3, 2, 16'h0000, 16'h00FD, 0, 0);
      chk("pull2_sp", m_sp_wb, 16'h00FF);
      chk("pull2_val", m_dst, 16'h1234);
      chk("pull2_lat", 16'(m_lat), 16'd6);
      idle(1);

      // single-byte pull into p with wrap
      mem[8'h00] = 8'hA5; ref_mem[8'h00] = 8'hA5;
      run_op(2, 1, 16'h0000, 16'h00FF, 0, 0);
      chk("pull1_sp", m_sp_wb, 16'h0000);
      chk("pull1_val", m_dst, 16'h00A5);
      chk("pull1_lat", 16'(m_lat), 16'd4);
      idle(1);

      // stall on the first push byte
      run_op(1, 0, 16'hBEEF, 16'h0080, 3, 0);
      chk("stall_lat", 16'(m_lat), 16'd6);
      chk("stall_hi", 16'(mem[8'h80]), 16'h00BE);
      chk("stall_lo", 16'(mem[8'h7F]), 16'h00EF);
      idle(1);

      // reset after the first pulled byte of a PULL2
      abort_at = 2;
      aborted  = 0;
      run_op(3, 1, 16'h0000, 16'h00FD, 0, 0);
      abort_at = -1;
      aborted  = 0;
      bus.req_valid = 1'b0;
      cycle('0, 1'b0, 0);
      reset = 1'b1;
      idle(2);

      // reserved opcode
      reserved_req(5);
      idle(2);

      // randomized traffic
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 9) == 0) reserved_req(int'($urandom_range(4, 7)));
         r_op = int'($urandom_range(0, 3));
         run_op(r_op, int'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                rand_wait(), rand_wait());
         if ($urandom_range(0, 1) != 0) idle(int'($urandom_range(1, 2)));
      end
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
